// File: rtl/led_refresh_scheduler.sv
// Frame refresh sequencer: reads each LED's GRB word from the colour RAM, hands it
// round-robin to the per-strip serializers, waits for them to drain, then holds the latch gap.
module led_refresh_scheduler #(
  parameter int NUM_STRIPS     = 4,
  parameter int LEDS_PER_STRIP = 30,
  parameter int ADDR_W         = 8,
  parameter int LATCH_CYCLES   = 6000
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  frame_done,
  output logic                  ram_rd_en,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [23:0]           ram_rd_data,
  output logic [23:0]           pix_data,
  output logic [NUM_STRIPS-1:0] pix_valid,
  input  logic [NUM_STRIPS-1:0] pix_ready,
  input  logic [NUM_STRIPS-1:0] strip_busy,
  output logic                  busy,
  output logic                  latch_active,
  output logic                  frame_ack,
  output logic                  frame_skipped,
  output logic [2:0]            state_dbg
);

  localparam int SW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
  localparam int CW = $clog2(LEDS_PER_STRIP + 1);
  localparam int LW = $clog2(LATCH_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_READ, S_WAIT_DATA, S_OFFER, S_DRAIN, S_LATCH
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt [NUM_STRIPS];
  logic [SW-1:0]   rr_ptr, sel, pick, pos;
  logic [LW-1:0]   lat_cnt;
  logic [NUM_STRIPS-1:0] elig;
  logic            found, last_led;

  assign state_dbg = state;

  // Eligibility, round-robin pick starting at rr_ptr, and "this handshake ends the frame".
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pos      = '0;
    elig     = '0;
    last_led = 1'b1;
    for (int s = 0; s < NUM_STRIPS; s++) begin
      elig[s] = pix_ready[s] && (cnt[s] < CW'(LEDS_PER_STRIP));
      if (SW'(s) == sel) begin
        if (cnt[s] != CW'(LEDS_PER_STRIP - 1)) last_led = 1'b0;
      end else if (cnt[s] != CW'(LEDS_PER_STRIP)) begin
        last_led = 1'b0;
      end
    end
    for (int i = 0; i < NUM_STRIPS; i++) begin
      pos = (int'(rr_ptr) + i >= NUM_STRIPS) ? SW'(int'(rr_ptr) + i - NUM_STRIPS)
                                              : SW'(int'(rr_ptr) + i);
      if (!found && elig[pos]) begin
        found = 1'b1;
        pick  = pos;
      end
    end
  end

  // Handshake: a word moves when pix_valid[s] and pix_ready[s] are both high on a rising
  // edge; once raised, pix_valid[s] holds with pix_data stable until that edge.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (frame_done && enable) next_state = S_SELECT;
      S_SELECT:    if (found) next_state = S_READ;
      S_READ:      next_state = S_WAIT_DATA;
      S_WAIT_DATA: next_state = S_OFFER;
      S_OFFER:     if (pix_ready[sel]) next_state = last_led ? S_DRAIN : S_SELECT;
      S_DRAIN:     if (strip_busy == '0) next_state = S_LATCH;
      S_LATCH:     if (lat_cnt == LW'(LATCH_CYCLES - 1)) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ram_rd_en     <= 1'b0;
      ram_addr      <= '0;
      pix_data      <= '0;
      pix_valid     <= '0;
      busy          <= 1'b0;
      latch_active  <= 1'b0;
      frame_ack     <= 1'b0;
      frame_skipped <= 1'b0;
      rr_ptr        <= '0;
      sel           <= '0;
      lat_cnt       <= '0;
      for (int s = 0; s < NUM_STRIPS; s++) cnt[s] <= '0;
    end else begin
      state         <= next_state;
      ram_rd_en     <= (next_state == S_READ);
      busy          <= (next_state != S_IDLE);
      latch_active  <= (next_state == S_LATCH);
      frame_ack     <= (state == S_LATCH) && (next_state == S_IDLE);
      frame_skipped <= frame_done && (state != S_IDLE);
      pix_valid     <= (next_state == S_OFFER) ? (NUM_STRIPS'(1) << sel) : '0;
      case (state)
        S_IDLE: begin
          if (next_state == S_SELECT) begin
            rr_ptr <= '0;
            for (int s = 0; s < NUM_STRIPS; s++) cnt[s] <= '0;
          end
        end
        S_SELECT: begin
          if (found) begin
            sel      <= pick;
            ram_addr <= ADDR_W'(int'(pick) * LEDS_PER_STRIP + int'(cnt[pick]));
          end
        end
        S_WAIT_DATA: pix_data <= ram_rd_data;
        S_OFFER: begin
          if (pix_ready[sel]) begin
            if (cnt[sel] != CW'(LEDS_PER_STRIP)) cnt[sel] <= cnt[sel] + CW'(1);
            rr_ptr <= (sel == SW'(NUM_STRIPS - 1)) ? '0 : sel + SW'(1);
          end
        end
        S_DRAIN: lat_cnt <= '0;
        S_LATCH: lat_cnt <= lat_cnt + LW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_refresh_scheduler.sv
// Bench for led_refresh_scheduler: directed frames plus random backpressure, checked
// against a round-robin reference model fed from the observed ready history.
module tb_led_refresh_scheduler;
  localparam int NS    = 4;
  localparam int LPS   = 3;
  localparam int AW    = 8;
  localparam int LC    = 20;
  localparam int TOTAL = NS * LPS;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          frame_done = 1'b0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [23:0]   ram_rd_data = '0;
  logic [23:0]   pix_data;
  logic [NS-1:0] pix_valid;
  logic [NS-1:0] pix_ready = '0;
  logic [NS-1:0] strip_busy = '0;
  logic          busy, latch_active, frame_ack, frame_skipped;
  logic [2:0]    state_dbg;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [23:0]   mem [256];
  logic [AW-1:0] got_addr_q[$];

  led_refresh_scheduler #(
    .NUM_STRIPS(NS), .LEDS_PER_STRIP(LPS), .ADDR_W(AW), .LATCH_CYCLES(LC)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .enable(enable), .frame_done(frame_done),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .strip_busy(strip_busy), .busy(busy), .latch_active(latch_active),
    .frame_ack(frame_ack), .frame_skipped(frame_skipped), .state_dbg(state_dbg)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous-read colour RAM
  always @(posedge sys_clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge sys_clk); #1;
  endtask

  task automatic sample();
    @(negedge sys_clk); #1;
  endtask

  // Reference model state: LEDs served per strip and the round-robin start point.
  int served [NS];
  int rr = 0, hs_count = 0, pend = 0, rd_cyc = 0, cyc = 0, s_exp = 0, pos = 0;
  logic [NS-1:0] prev_ready = '0, prev_valid = '0, prev_sbusy = '0;
  logic [23:0]   prev_data = '0;
  logic [AW-1:0] prev_addr = '0, pend_addr = '0;
  logic prev_busy = 0, prev_hs = 0, prev_fd = 0, prev_rst = 0, prev_latch = 0;

  always @(negedge sys_clk) begin
    cyc++;
    if (!rst_n) begin
      prev_valid = '0; prev_busy = 0; prev_hs = 0; prev_fd = 0; prev_rst = 0;
      prev_latch = 0; prev_sbusy = '0; prev_ready = '0;
    end else begin
      if (busy && !prev_busy) begin
        for (int s = 0; s < NS; s++) served[s] = 0;
        rr = 0;
        hs_count = 0;
      end
      if (prev_fd || frame_skipped) check("skip", frame_skipped, prev_fd && prev_busy);
      if (prev_rst && !ram_rd_en) check("addr_hold", ram_addr, prev_addr);
      if (ram_rd_en) begin
        s_exp = -1;
        for (int i = 0; i < NS; i++) begin
          pos = (rr + i) % NS;
          if (s_exp < 0 && prev_ready[pos] && served[pos] < LPS) s_exp = pos;
        end
        check("rd_eligible", s_exp >= 0, 1);
        if (s_exp < 0) s_exp = 0;
        pend      = s_exp;
        pend_addr = AW'(s_exp * LPS + served[s_exp]);
        rd_cyc    = cyc;
        check("rd_addr", ram_addr, pend_addr);
        got_addr_q.push_back(ram_addr);
      end
      if (prev_hs) begin
        check("valid_drop", pix_valid, 0);
      end else if (pix_valid != 0 && prev_valid == 0) begin
        check("offer_latency", cyc, rd_cyc + 2);
        check("offer_onehot", pix_valid, 1 << pend);
        check("offer_data", pix_data, mem[pend_addr]);
      end else if (prev_valid != 0) begin
        check("hold_valid", pix_valid, prev_valid);
        check("hold_data", pix_data, prev_data);
      end
      prev_hs = pix_valid[pend] && pix_ready[pend];
      if (prev_hs) begin
        served[pend]++;
        rr = (pend + 1) % NS;
        hs_count++;
      end
      if (latch_active && !prev_latch) begin
        check("latch_after_hs", hs_count, TOTAL);
        check("latch_after_drain", prev_sbusy, 0);
      end
      prev_valid = pix_valid; prev_data = pix_data; prev_busy = busy;
      prev_fd = frame_done; prev_rst = 1; prev_latch = latch_active;
      prev_sbusy = strip_busy; prev_ready = pix_ready; prev_addr = ram_addr;
    end
  end

  task automatic pulse_frame();
    got_addr_q.delete();
    drive_edge(); frame_done = 1'b1;
    drive_edge(); frame_done = 1'b0;
  endtask

  task automatic finish_frame(input bit rand_ready, input bit fd_last, input int lat_init);
    int lat, guard;
    bit acked;
    lat = lat_init; guard = 0; acked = 0;
    while (!acked && guard < 3000) begin
      drive_edge();
      if (rand_ready) pix_ready = NS'($urandom) | NS'($urandom);
      frame_done = fd_last && (lat == LC - 1);
      sample();
      if (latch_active) lat++;
      if (frame_ack) acked = 1;
      guard++;
    end
    check("frame_ack_seen", acked, 1);
    check("latch_len", lat, LC);
    check("hs_total", hs_count, TOTAL);
    check("skip_last_latch", frame_skipped, fd_last);
    frame_done = 1'b0;
    drive_edge(); pix_ready = '1; sample();
    check("ack_pulse", frame_ack, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic idle_check(input string tag, input int n);
    int act;
    act = 0;
    repeat (n) begin
      drive_edge(); sample();
      if (busy || ram_rd_en || frame_skipped || pix_valid != 0) act++;
    end
    check(tag, act, 0);
  endtask

  initial begin
    int g, lat_hi, rd_seen;
    for (int a = 0; a < 256; a++) mem[a] = 24'($urandom);

    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_latch", latch_active, 0);
    check("rst_ack", frame_ack, 0);
    check("rst_skip", frame_skipped, 0);
    rst_n = 1'b1; enable = 1'b1; pix_ready = '1;

    // Full frame, all strips ready: exact latency and strip-interleaved address order
    pulse_frame();
    sample(); check("t1_busy", busy, 1); check("t1_rd_en", ram_rd_en, 0);
    sample(); check("t2_rd_en", ram_rd_en, 1); check("t2_addr", ram_addr, 0);
    sample(); check("t3_valid", pix_valid, 0);
    sample(); check("t4_valid", pix_valid, 4'b0001); check("t4_data", pix_data, mem[0]);
    finish_frame(0, 0, 0);
    check("order_len", got_addr_q.size(), TOTAL);
    for (int k = 0; k < LPS; k++)
      for (int s = 0; s < NS; s++)
        if (k * NS + s < got_addr_q.size()) check("order", got_addr_q[k * NS + s], s * LPS + k);

    // Asynchronous reset in the middle of an offer
    pulse_frame();
    g = 0;
    sample();
    while (pix_valid == 0 && g < 20) begin drive_edge(); sample(); g++; end
    check("offer_reached", pix_valid != 0, 1);
    rst_n = 1'b0;
    #1;
    check("arst_pix_valid", pix_valid, 0);
    check("arst_rd_en", ram_rd_en, 0);
    check("arst_busy", busy, 0);
    check("arst_latch", latch_active, 0);
    @(negedge sys_clk);
    drive_edge(); rst_n = 1'b1;
    pulse_frame();
    g = 0;
    sample();
    while (!ram_rd_en && g < 10) begin drive_edge(); sample(); g++; end
    check("post_rst_addr", ram_addr, 0);
    finish_frame(0, 0, 0);

    // Strip 1 not ready for 30 cycles
    pix_ready = 4'b1101;
    pulse_frame();
    repeat (30) begin drive_edge(); sample(); end
    finish_frame(1, 0, 0);
    check("bp_len", got_addr_q.size(), TOTAL);
    if (got_addr_q.size() >= 4) begin
      check("bp_0", got_addr_q[0], 0);
      check("bp_1", got_addr_q[1], 6);
      check("bp_2", got_addr_q[2], 9);
      check("bp_3", got_addr_q[3], 1);
    end

    // Random backpressure frames
    for (int f = 0; f < 4; f++) begin
      pulse_frame();
      finish_frame(1, 0, 0);
    end

    // Drain: strip 2 keeps shifting for 50 cycles after the last handshake
    strip_busy = 4'b0100;
    pulse_frame();
    g = 0;
    while (hs_count < TOTAL && g < 500) begin drive_edge(); sample(); g++; end
    check("drain_hs_reached", hs_count, TOTAL);
    lat_hi = 0;
    repeat (50) begin drive_edge(); sample(); if (latch_active) lat_hi++; end
    check("drain_hold", lat_hi, 0);
    check("drain_busy", busy, 1);
    drive_edge(); strip_busy = '0; sample();
    check("drain_pre", latch_active, 0);
    drive_edge(); sample();
    check("drain_rise", latch_active, 1);
    finish_frame(0, 0, 1);

    // frame_done while busy, and again in the final latch cycle
    pulse_frame();
    repeat (6) begin drive_edge(); sample(); end
    drive_edge(); frame_done = 1'b1;
    drive_edge(); frame_done = 1'b0;
    sample(); check("skip_pulse", frame_skipped, 1);
    drive_edge(); sample(); check("skip_once", frame_skipped, 0);
    finish_frame(0, 1, 0);
    idle_check("no_queued_frame", 10);

    enable = 1'b0;
    pulse_frame();
    idle_check("disabled_ignore", 10);
    enable = 1'b1;

    // Nobody ready, then only strip 3
    pix_ready = '0;
    pulse_frame();
    rd_seen = 0;
    repeat (10) begin drive_edge(); sample(); if (ram_rd_en) rd_seen++; end
    check("noelig_rd", rd_seen, 0);
    check("noelig_busy", busy, 1);
    drive_edge(); pix_ready = 4'b1000;
    g = 0;
    sample();
    while (!ram_rd_en && g < 10) begin drive_edge(); sample(); g++; end
    check("noelig_first_addr", ram_addr, 9);
    pix_ready = '1;
    finish_frame(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
